if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised, elastic fetch-to-decode stage buffer: a DEPTH-entry FIFO of (program counter, instruction) pairs with valid/ready handshakes on both sides and a synchronous flush. It sits between the fetch stage and the decode stage. It replaces the unconditional per-cycle IF/ID register, so that fetch can run ahead when decode stalls and branch redirects can discard in-flight instructions.

## Interface
Parameters:
- ADDR_WIDTH, default 32: program-counter width.
- DATA_WIDTH, default 32: instruction width.
- DEPTH, default 2: number of entries; must be a power of two and at least 2.

Ports:
- clock  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all entries; active-high.
- if_valid  input  1  fetch presents a valid pair.
- if_ready  output  1  buffer can accept a pair this cycle.
- if_program_counter  input  ADDR_WIDTH  PC of the fetched instruction.
- if_instruction  input  DATA_WIDTH  fetched instruction word.
- id_valid  output  1  head entry is valid.
- id_ready  input  1  decode consumes the head this cycle.
- id_program_counter  output  ADDR_WIDTH  PC of the head entry.
- id_instruction  output  DATA_WIDTH  instruction of the head entry.
- occupancy  output  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Push: on a rising edge with if_valid and if_ready high, with flush low. The pair is written at the write pointer, and the write pointer advances modulo DEPTH.
- Pop: on a rising edge with id_valid and id_ready high, with flush low. The read pointer advances modulo DEPTH.
- if_ready is high exactly when occupancy is less than DEPTH. It is derived from registered state only, with no combinational path from id_ready.
- id_valid is high exactly when occupancy is not 0. id_program_counter and id_instruction show the entry at the read pointer.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. This is legal at any non-full, non-empty occupancy.
- Push and pop with occupancy 0: no pass-through. The pushed pair becomes the head after the edge.
- Push while full: impossible, because if_ready is low. if_valid held high with if_ready low is a stall, not a loss. Fetch must hold its data.
- Pop while empty: ignored. id_ready with id_valid low has no effect.
- Flush has priority over push and pop. At the edge, occupancy and both pointers return to 0, and any concurrent push or pop is discarded.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by occupancy, never by pointer equality.
- Reset: asserting reset at any time, including mid-stream, immediately clears the pointers and occupancy. After reset, occupancy=0, id_valid=0 and if_ready=1. Storage contents are not reset.

## Timing
- Latency: a pair pushed at edge N appears on id_* with id_valid=1 after edge N, so it is consumable at edge N+1.
- Throughput: one push and one pop per cycle in steady state.
- All outputs are functions of registered state. Decode-side outputs change only on a clock edge or on reset assertion.
- Flush asserted at edge N: id_valid=0 and if_ready=1 after edge N. The first post-flush push is accepted at edge N+1.
- Reset release is synchronised by the system. The block first acts on the first rising edge with reset high.

## Configuration
- IF_ID_QUEUE_ZERO_BUBBLE_EN, when defined: id_program_counter and id_instruction are forced to 0 whenever id_valid is 0. This covers reset, empty and post-flush. Decode therefore sees an all-zero word (NOP) in bubbles.
- When not defined: the data outputs show stale storage while id_valid=0, and decode must qualify them with id_valid.

## Structure
- Shared header/package holds:
  - the existing ENABLE/DISABLE constants and the INST_ADDR_BUS/INST_DATA_BUS widths, used as the ADDR_WIDTH/DATA_WIDTH defaults;
  - the ZERO_WORD constant used by the bubble feature.
- One sub-module, if_id_queue_storage: a DEPTH x (ADDR_WIDTH+DATA_WIDTH) register array with one synchronous write port and one asynchronous read port, not reset.
- Pointer, occupancy, flush and handshake logic stays in if_id_queue.

## Test plan
- Reset: hold reset low for 3 cycles with if_valid=1. Required: occupancy=0, id_valid=0, if_ready=1; with ZERO_BUBBLE_EN, id_instruction=0.
- Fill and stall: DEPTH=2, id_ready=0, push PC 0x100/0x104. Required: occupancy=2 and if_ready=0. A third pair 0x108 held for 2 cycles is not accepted.
- Drain in order: from that full state, set id_ready=1. Required: 0x100 then 0x104, one per cycle, then id_valid=0. 0x108 is accepted once if_ready returns to 1.
- Streaming with wrap-around: DEPTH=4, push and pop every cycle for 10 pairs (0x200..0x224). Required: occupancy stays 1, outputs come out in order, and there is no loss across pointer wrap.
- Flush priority: occupancy=3 with flush, if_valid and id_ready all high. Required: after the edge, occupancy=0 and id_valid=0. The concurrent pair is absent, and the next push appears as the head.
- Async reset mid-stream: drop reset between edges with occupancy=2. Required: id_valid falls before the next edge, and queue contents are never emitted after release.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the fetch-to-decode queue: bus widths, enable flags, bubble word.
// Pure declarations; no latency or backpressure of its own.
package if_id_queue_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_DATA_BUS = 32;

   localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/if_id_queue_storage.sv
// DEPTH x WIDTH entry array: one synchronous write port, one asynchronous read port, not reset.
// Write visible on the read port after the edge; no backpressure (caller gates the write enable).
module if_id_queue_storage #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clock,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_dat
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Elastic IF/ID buffer of (pc, instruction) pairs with flush; IF_ID_QUEUE_ZERO_BUBBLE_EN zeroes data when empty.
// Latency: pair pushed at edge N is the head after edge N. Backpressure: if_ready low only when full, from registered occupancy.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int ADDR_WIDTH = INST_ADDR_BUS,
   parameter int DATA_WIDTH = INST_DATA_BUS,
   parameter int DEPTH      = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       if_valid,
   output logic                       if_ready,
   input  logic [ADDR_WIDTH-1:0]      if_program_counter,
   input  logic [DATA_WIDTH-1:0]      if_instruction,
   output logic                       id_valid,
   input  logic                       id_ready,
   output logic [ADDR_WIDTH-1:0]      id_program_counter,
   output logic [DATA_WIDTH-1:0]      id_instruction,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

`ifdef IF_ID_QUEUE_ZERO_BUBBLE_EN
   localparam logic ZERO_BUBBLE = ENABLE;
`else
   localparam logic ZERO_BUBBLE = DISABLE;
`endif

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d;
   logic          push, pop;
   logic [EW-1:0] head_dat;

   // Full/empty come from occupancy alone so wrapped pointers are never ambiguous.
   assign if_ready  = (occ_q < FULL_OCC);
   assign id_valid  = (occ_q != '0);
   assign occupancy = occ_q;

   assign push = if_valid & if_ready & ~flush;
   assign pop  = id_valid & id_ready & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   if_id_queue_storage #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_storage (
      .clock   (clock),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_dat  ({if_program_counter, if_instruction}),
      .rd_addr (rd_ptr_q),
      .rd_dat  (head_dat)
   );

   always_comb begin
      id_program_counter = head_dat[EW-1:DATA_WIDTH];
      id_instruction     = head_dat[DATA_WIDTH-1:0];
      if (ZERO_BUBBLE && !id_valid) begin
         id_program_counter = ADDR_WIDTH'(ZERO_WORD);
         id_instruction     = DATA_WIDTH'(ZERO_WORD);
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2 and DEPTH=4 instances driven side by side against a queue model.
module tb_if_id_queue;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } pair_t;

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic        idr;
      logic        fl;
      int          occ;
      logic        ifr;
      logic        idv;
      logic [31:0] head;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic        fl2 = 1'b0, iv2 = 1'b0, idr2 = 1'b0;
   logic [31:0] pcin2 = '0, insin2 = '0;
   logic        ifr2, idv2;
   logic [31:0] pcout2, insout2;
   logic [1:0]  occ2;

   logic        fl4 = 1'b0, iv4 = 1'b0, idr4 = 1'b0;
   logic [31:0] pcin4 = '0, insin4 = '0;
   logic        ifr4, idv4;
   logic [31:0] pcout4, insout4;
   logic [2:0]  occ4;

   if_id_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2)) u_dut2 (
      .clock(clock), .reset(reset), .flush(fl2),
      .if_valid(iv2), .if_ready(ifr2), .if_program_counter(pcin2), .if_instruction(insin2),
      .id_valid(idv2), .id_ready(idr2), .id_program_counter(pcout2), .id_instruction(insout2),
      .occupancy(occ2)
   );

   if_id_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
      .clock(clock), .reset(reset), .flush(fl4),
      .if_valid(iv4), .if_ready(ifr4), .if_program_counter(pcin4), .if_instruction(insin4),
      .id_valid(idv4), .id_ready(idr4), .id_program_counter(pcout4), .id_instruction(insout4),
      .occupancy(occ4)
   );

   int checks = 0;
   int errors = 0;
   pair_t q2[$];
   pair_t q4[$];
   vec_t  tbl[11];

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic post_check(input string tag, input int depth, input int size, input logic rdy,
                             input logic vld, input int occ, input logic [31:0] pc,
                             input logic [31:0] ins, input pair_t head);
      chk({tag, " occupancy"}, 64'(occ), 64'(size));
      chk({tag, " id_valid"}, 64'(vld), 64'(size != 0));
      chk({tag, " if_ready"}, 64'(rdy), 64'(size < depth));
      if (size != 0) begin
         chk({tag, " head pc"}, 64'(pc), 64'(head.pc));
         chk({tag, " head ins"}, 64'(ins), 64'(head.ins));
      end
`ifdef IF_ID_QUEUE_ZERO_BUBBLE_EN
      else begin
         chk({tag, " bubble pc"}, 64'(pc), 64'(0));
         chk({tag, " bubble ins"}, 64'(ins), 64'(0));
      end
`endif
   endtask

   // One clock of the DEPTH=2 instance; called right after an edge (+1).
   task automatic tick2(input logic iv, input logic [31:0] pc, input logic idr, input logic fl);
      logic acc_push, acc_pop;
      iv2 = iv; pcin2 = pc; insin2 = ins_of(pc); idr2 = idr; fl2 = fl;
      acc_push = iv && !fl && (q2.size() < 2);
      acc_pop  = idr && !fl && (q2.size() > 0);
      if (acc_pop) begin
         chk("d2 pop pc", 64'(pcout2), 64'(q2[0].pc));
         chk("d2 pop ins", 64'(insout2), 64'(q2[0].ins));
      end
      @(posedge clock); #1;
      if (fl) q2.delete();
      else begin
         if (acc_pop) void'(q2.pop_front());
         if (acc_push) q2.push_back('{pc: pc, ins: ins_of(pc)});
      end
      post_check("d2", 2, q2.size(), ifr2, idv2, int'(occ2), pcout2, insout2,
                 (q2.size() != 0) ? q2[0] : pair_t'(0));
   endtask

   task automatic tick4(input logic iv, input logic [31:0] pc, input logic idr, input logic fl);
      logic acc_push, acc_pop;
      iv4 = iv; pcin4 = pc; insin4 = ins_of(pc); idr4 = idr; fl4 = fl;
      acc_push = iv && !fl && (q4.size() < 4);
      acc_pop  = idr && !fl && (q4.size() > 0);
      if (acc_pop) begin
         chk("d4 pop pc", 64'(pcout4), 64'(q4[0].pc));
         chk("d4 pop ins", 64'(insout4), 64'(q4[0].ins));
      end
      @(posedge clock); #1;
      if (fl) q4.delete();
      else begin
         if (acc_pop) void'(q4.pop_front());
         if (acc_push) q4.push_back('{pc: pc, ins: ins_of(pc)});
      end
      post_check("d4", 4, q4.size(), ifr4, idv4, int'(occ4), pcout4, insout4,
                 (q4.size() != 0) ? q4[0] : pair_t'(0));
   endtask

   initial begin
      //           iv    pc           idr   fl    occ ifr   idv   head
      tbl[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h100};
      tbl[1]  = '{1'b1, 32'h104, 1'b0, 1'b0, 2, 1'b0, 1'b1, 32'h100};
      tbl[2]  = '{1'b1, 32'h108, 1'b0, 1'b0, 2, 1'b0, 1'b1, 32'h100};
      tbl[3]  = '{1'b1, 32'h108, 1'b0, 1'b0, 2, 1'b0, 1'b1, 32'h100};
      tbl[4]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h104};
      tbl[5]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h108};
      tbl[6]  = '{1'b0, 32'h000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h000};
      tbl[7]  = '{1'b1, 32'h10C, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h10C};
      tbl[8]  = '{1'b0, 32'h000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h000};
      tbl[9]  = '{1'b1, 32'h110, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h110};
      tbl[10] = '{1'b0, 32'h000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h000};

      // Reset held with fetch presenting data.
      iv2 = 1'b1; pcin2 = 32'hDEAD; insin2 = 32'hBEEF;
      iv4 = 1'b1; pcin4 = 32'hDEAD; insin4 = 32'hBEEF;
      repeat (3) @(posedge clock);
      #1;
      chk("rst d2 occupancy", 64'(occ2), 64'(0));
      chk("rst d2 id_valid", 64'(idv2), 64'(0));
      chk("rst d2 if_ready", 64'(ifr2), 64'(1));
      chk("rst d4 occupancy", 64'(occ4), 64'(0));
      chk("rst d4 id_valid", 64'(idv4), 64'(0));
      chk("rst d4 if_ready", 64'(ifr4), 64'(1));
`ifdef IF_ID_QUEUE_ZERO_BUBBLE_EN
      chk("rst d2 bubble ins", 64'(insout2), 64'(0));
`endif
      iv2 = 1'b0; iv4 = 1'b0;
      reset = 1'b1;

      // Fill, stall, drain, empty push, flush on DEPTH=2.
      for (int i = 0; i < 11; i++) begin
         tick2(tbl[i].iv, tbl[i].pc, tbl[i].idr, tbl[i].fl);
         chk($sformatf("vec%0d occupancy", i), 64'(occ2), 64'(tbl[i].occ));
         chk($sformatf("vec%0d if_ready", i), 64'(ifr2), 64'(tbl[i].ifr));
         chk($sformatf("vec%0d id_valid", i), 64'(idv2), 64'(tbl[i].idv));
         if (tbl[i].idv) chk($sformatf("vec%0d head pc", i), 64'(pcout2), 64'(tbl[i].head));
      end
      iv2 = 1'b0; idr2 = 1'b0; fl2 = 1'b0;

      // Streaming across pointer wrap on DEPTH=4.
      tick4(1'b1, 32'h200, 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) begin
         tick4(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
         chk($sformatf("stream%0d occupancy", i), 64'(occ4), 64'(1));
      end
      tick4(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stream drained", 64'(idv4), 64'(0));

      // Flush beats concurrent push and pop.
      tick4(1'b1, 32'h300, 1'b0, 1'b0);
      tick4(1'b1, 32'h304, 1'b0, 1'b0);
      tick4(1'b1, 32'h308, 1'b0, 1'b0);
      chk("pre-flush occupancy", 64'(occ4), 64'(3));
      tick4(1'b1, 32'h30C, 1'b1, 1'b1);
      chk("flush occupancy", 64'(occ4), 64'(0));
      chk("flush id_valid", 64'(idv4), 64'(0));
      tick4(1'b1, 32'h310, 1'b0, 1'b0);
      chk("post-flush head", 64'(pcout4), 64'(32'h310));
      tick4(1'b1, 32'h314, 1'b0, 1'b0);
      chk("pre-reset occupancy", 64'(occ4), 64'(2));

      // Asynchronous reset between edges.
      iv4 = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("async rst id_valid", 64'(idv4), 64'(0));
      chk("async rst occupancy", 64'(occ4), 64'(0));
      q4.delete();
      q2.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) tick4(1'b0, 32'h0, 1'b1, 1'b0);
      tick4(1'b1, 32'h400, 1'b1, 1'b0);
      chk("post-reset head", 64'(pcout4), 64'(32'h400));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
